fp_norm_pipe: RTL

- Parametrised, pipelined leading-zero counter and normaliser for the floating-point ALU datapath. Successor to the combinational leading-one detector.
- Takes an unnormalised mantissa plus biased exponent and produces:
  - the leading-zero count;
  - the left-normalised mantissa;
  - the adjusted exponent, clamped to subnormal on underflow.
- Sits between the add/sub mantissa stage and the rounder; valid/ready handshake on both sides.

---
 rtl/fp_norm_pkg.sv | 23 ++
 rtl/lzc_chunk.sv | 20 ++
 rtl/fp_norm_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// Shared definitions for the floating-point normaliser: result flags,
// default geometry and width helpers used by fp_norm_pipe.
package fp_norm_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int DEF_EXP_W = 8;

    typedef struct packed {
        logic zero;
        logic uflow;
    } norm_flags_t;

    // Leading-zero count must represent the all-zero value WIDTH itself.
    function automatic int clog2_p1(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int nchunk(input int w, input int c);
        return w / c;
    endfunction

endpackage

// File: rtl/lzc_chunk.sv
// Combinational leading-zero detector for one CHUNK-bit slice of the mantissa.
module lzc_chunk #(
    parameter int CHUNK = 8,
    localparam int CCW = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] d,
    output logic [CCW-1:0]   cnt,
    output logic             all_zero
);

    // Scanning upward lets the highest set bit win; cnt is ignored when all_zero.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (d[i]) cnt = CCW'(CHUNK - 1 - i);
        end
        all_zero = ~|d;
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage pipelined leading-zero counter and mantissa normaliser with
// subnormal exponent clamping and valid/ready flow control on both sides.
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK,
    parameter int EXP_W = DEF_EXP_W,
    localparam int CW = clog2_p1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic [CW-1:0]    out_lzc,
    output logic             out_zero,
    output logic             out_uflow
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CCW    = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int CMPW   = (CW > EXP_W) ? CW : EXP_W;

    // Returns {uflow, exponent}: exp - lzc, or zero with uflow when it would go negative.
    function automatic logic [EXP_W:0] clamp_exp(input logic [EXP_W-1:0] e,
                                                 input logic [CW-1:0]    lzc);
        logic signed [CMPW:0] diff;
        diff = $signed({1'b0, CMPW'(e)}) - $signed({1'b0, CMPW'(lzc)});
        if (diff < 0) return {1'b1, EXP_W'(0)};
        return {1'b0, diff[EXP_W-1:0]};
    endfunction

    logic             vld_p1, vld_p2;
    logic             rdy_p1, rdy_p2;
    logic [WIDTH-1:0] mant_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [CW-1:0]    lzc_p1;

    logic [CCW-1:0]    chunk_cnt [NCHUNK];
    logic [NCHUNK-1:0] chunk_zero;
    logic [CW-1:0]     lzc_c;

    logic [WIDTH-1:0]  mant_c;
    logic [EXP_W-1:0]  exp_c;
    logic [CMPW-1:0]   shamt_c;
    logic              uflow_c;
    norm_flags_t       flags_c;

    assign rdy_p2    = !vld_p2 || out_ready;
    assign rdy_p1    = !vld_p1 || rdy_p2;
    assign in_ready  = rdy_p1;
    assign out_valid = vld_p2;

    for (genvar k = 0; k < NCHUNK; k++) begin : g_chunk
        lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
            .d        (in_mant[k*CHUNK +: CHUNK]),
            .cnt      (chunk_cnt[k]),
            .all_zero (chunk_zero[k])
        );
    end

    always_comb begin : lzc_combine
        logic found;
        found = 1'b0;
        lzc_c = CW'(WIDTH);
        for (int k = NCHUNK - 1; k >= 0; k--) begin
            if (!found && !chunk_zero[k]) begin
                lzc_c = CW'((NCHUNK - 1 - k) * CHUNK) + CW'(chunk_cnt[k]);
                found = 1'b1;
            end
        end
    end

    // Stage 1 boundary: raw mantissa, exponent and full leading-zero count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (rdy_p1) vld_p1 <= in_valid;
            if (rdy_p2) vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && rdy_p1) begin
            mant_p1 <= in_mant;
            exp_p1  <= in_exp;
            lzc_p1  <= lzc_c;
        end
    end

    always_comb begin
        {uflow_c, exp_c} = clamp_exp(exp_p1, lzc_p1);
        shamt_c          = uflow_c ? CMPW'(exp_p1) : CMPW'(lzc_p1);
        mant_c           = mant_p1 << shamt_c;
        flags_c.zero     = (lzc_p1 == CW'(WIDTH));
        flags_c.uflow    = uflow_c;
        if (flags_c.zero) begin
            mant_c        = '0;
            exp_c         = '0;
            flags_c.uflow = 1'b0;
        end
    end

    // Stage 2 boundary: normalised result; cleared on reset so nothing stale shows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_mant  <= '0;
            out_exp   <= '0;
            out_lzc   <= '0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (vld_p1 && rdy_p2) begin
            out_mant  <= mant_c;
            out_exp   <= exp_c;
            out_lzc   <= lzc_p1;
            out_zero  <= flags_c.zero;
            out_uflow <= flags_c.uflow;
        end
    end

endmodule
